// File: rtl/test_status_monitor.sv
// test_status_monitor
// Bench-side end-of-test monitor for 1..NUM_HARTS harts. It watches each
// hart's retire stream for the end-of-test WFI word and captures that hart's
// a0 at that point. It then produces one sticky done/pass/timeout verdict,
// together with the first failing hart and its a0 value.
// Optional feature macro: TEST_STATUS_MONITOR_STALL_DETECT_EN adds per-hart
// idle-retire stall detection, limited by STALL_CYCLES.
module test_status_monitor #(
  parameter int          NUM_HARTS      = 1,
  parameter logic [31:0] WFI_OPCODE     = 32'h10500073,
  parameter logic [31:0] PASS_VALUE     = 32'h0,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter int          CNT_W          = 32,
  parameter int          STALL_CYCLES   = 4096,
  localparam int         IDX_W          = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NUM_HARTS-1:0]    retire_valid,
  input  logic [32*NUM_HARTS-1:0] retire_instr,
  input  logic [32*NUM_HARTS-1:0] retire_a0,
  output logic [NUM_HARTS-1:0]    hart_done,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [IDX_W-1:0]        fail_hart,
  output logic [31:0]             fail_a0,
  output logic [CNT_W-1:0]        cycle_count
);

  // Reject parameter values the verdict logic cannot honour.
  if (NUM_HARTS < 1 || NUM_HARTS > 16) begin : g_bad_num_harts
    $error("test_status_monitor: NUM_HARTS must be in 1..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("test_status_monitor: TIMEOUT_CYCLES must be >= 2");
  end
  if (STALL_CYCLES < 1) begin : g_bad_stall
    $error("test_status_monitor: STALL_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state, state_n;
  logic                   fail_seen, fail_seen_n;
  logic [NUM_HARTS-1:0]   hart_done_n;
  logic                   done_n, pass_n, timeout_n;
  logic [IDX_W-1:0]       fail_hart_n;
  logic [31:0]            fail_a0_n;
  logic [CNT_W-1:0]       cycle_count_n;

  logic [NUM_HARTS-1:0]   hit;
  logic [NUM_HARTS-1:0]   fail_hit;
  logic [IDX_W-1:0]       fail_idx;
  logic [31:0]            fail_idx_a0;
  logic                   all_done;
  logic                   at_limit;
  logic [CNT_W-1:0]       count_inc;

  logic                   stall_any;
  logic [IDX_W-1:0]       stall_idx;

  // Decode first-time WFI retires per hart and pick the lowest failing one.
  always_comb begin
    hit         = '0;
    fail_hit    = '0;
    fail_idx    = '0;
    fail_idx_a0 = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      hit[i]      = retire_valid[i] && (retire_instr[32*i +: 32] == WFI_OPCODE) && !hart_done[i];
      fail_hit[i] = hit[i] && (retire_a0[32*i +: 32] != PASS_VALUE);
    end
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (fail_hit[i]) begin
        fail_idx    = IDX_W'(i);
        fail_idx_a0 = retire_a0[32*i +: 32];
      end
    end
  end

  assign all_done  = &(hart_done | hit);
  assign at_limit  = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign count_inc = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);

`ifdef TEST_STATUS_MONITOR_STALL_DETECT_EN
  localparam int SC_W = $clog2(STALL_CYCLES + 1);

  logic [SC_W-1:0]      stall_cnt   [NUM_HARTS];
  logic [SC_W-1:0]      stall_cnt_n [NUM_HARTS];
  logic [NUM_HARTS-1:0] stall_hit;

  // Per-hart idle counters; a retire or a finished hart keeps the counter at 0.
  always_comb begin
    stall_hit = '0;
    stall_any = 1'b0;
    stall_idx = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      stall_cnt_n[i] = '0;
      if (state == S_RUN && enable && !hart_done[i] && !retire_valid[i]) begin
        stall_cnt_n[i] = stall_cnt[i] + SC_W'(1);
        stall_hit[i]   = (stall_cnt[i] == SC_W'(STALL_CYCLES - 1));
      end
    end
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (stall_hit[i]) begin
        stall_any = 1'b1;
        stall_idx = IDX_W'(i);
      end
    end
  end

  // Stall counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        stall_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        stall_cnt[i] <= stall_cnt_n[i];
      end
    end
  end
`else
  assign stall_any = 1'b0;
  assign stall_idx = '0;
`endif

  // Next-state and next-verdict logic; IDLE and any return to IDLE clear everything.
  always_comb begin
    logic clear;
    clear         = 1'b0;
    state_n       = state;
    fail_seen_n   = fail_seen;
    hart_done_n   = hart_done;
    done_n        = done;
    pass_n        = pass;
    timeout_n     = timeout;
    fail_hart_n   = fail_hart;
    fail_a0_n     = fail_a0;
    cycle_count_n = cycle_count;

    case (state)
      S_IDLE: begin
        clear = 1'b1;
        if (enable) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_n = S_IDLE;
          clear   = 1'b1;
        end else begin
          cycle_count_n = count_inc;
          hart_done_n   = hart_done | hit;
          if (!fail_seen && |fail_hit) begin
            fail_seen_n = 1'b1;
            fail_hart_n = fail_idx;
            fail_a0_n   = fail_idx_a0;
          end
          if (all_done) begin
            state_n   = S_DONE;
            done_n    = 1'b1;
            pass_n    = !fail_seen && !(|fail_hit);
            timeout_n = 1'b0;
          end else if (stall_any) begin
            state_n     = S_DONE;
            done_n      = 1'b1;
            pass_n      = 1'b0;
            timeout_n   = 1'b1;
            fail_hart_n = stall_idx;
            fail_a0_n   = 32'hDEAD_57A1;
          end else if (at_limit) begin
            state_n   = S_DONE;
            done_n    = 1'b1;
            pass_n    = 1'b0;
            timeout_n = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_n = S_IDLE;
          clear   = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        clear   = 1'b1;
      end
    endcase

    if (clear) begin
      fail_seen_n   = 1'b0;
      hart_done_n   = '0;
      done_n        = 1'b0;
      pass_n        = 1'b0;
      timeout_n     = 1'b0;
      fail_hart_n   = '0;
      fail_a0_n     = '0;
      cycle_count_n = '0;
    end
  end

  // State and verdict registers; reset discards everything captured so far.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      fail_seen   <= 1'b0;
      hart_done   <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_hart   <= '0;
      fail_a0     <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_n;
      fail_seen   <= fail_seen_n;
      hart_done   <= hart_done_n;
      done        <= done_n;
      pass        <= pass_n;
      timeout     <= timeout_n;
      fail_hart   <= fail_hart_n;
      fail_a0     <= fail_a0_n;
      cycle_count <= cycle_count_n;
    end
  end

endmodule

// File: tb/tb_test_status_monitor.sv
// tb_test_status_monitor
// Directed bench for test_status_monitor with four harts and a 100-cycle
// timeout. Expected verdicts go into a scoreboard queue as stimulus is driven.
// They are popped and compared once the DUT has had its cycle to respond.
module tb_test_status_monitor;

  localparam int          NH  = 4;
  localparam logic [31:0] WFI = 32'h10500073;
  localparam logic [31:0] NOP = 32'h00000013;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [NH-1:0]     retire_valid;
  logic [32*NH-1:0]  retire_instr;
  logic [32*NH-1:0]  retire_a0;
  logic [NH-1:0]     hart_done;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [1:0]        fail_hart;
  logic [31:0]       fail_a0;
  logic [31:0]       cycle_count;

  typedef struct {
    logic        done;
    logic        pass;
    logic        timeout;
    logic [3:0]  hd;
    logic [1:0]  fh;
    logic [31:0] fa;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  test_status_monitor #(
    .NUM_HARTS      (NH),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .retire_valid (retire_valid),
    .retire_instr (retire_instr),
    .retire_a0    (retire_a0),
    .hart_done    (hart_done),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .fail_hart    (fail_hart),
    .fail_a0      (fail_a0),
    .cycle_count  (cycle_count)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic logic [32*NH-1:0] a0v(input logic [31:0] h3, input logic [31:0] h2,
                                           input logic [31:0] h1, input logic [31:0] h0);
    return {h3, h2, h1, h0};
  endfunction

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input logic d, input logic p, input logic t, input logic [3:0] hd,
                            input logic [1:0] fh, input logic [31:0] fa, input logic [31:0] cnt);
    exp_t e;
    e.done = d; e.pass = p; e.timeout = t; e.hd = hd; e.fh = fh; e.fa = fa; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      checkField({tag, ".done"},        32'(done),        32'(e.done));
      checkField({tag, ".pass"},        32'(pass),        32'(e.pass));
      checkField({tag, ".timeout"},     32'(timeout),     32'(e.timeout));
      checkField({tag, ".hart_done"},   32'(hart_done),   32'(e.hd));
      checkField({tag, ".fail_hart"},   32'(fail_hart),   32'(e.fh));
      checkField({tag, ".fail_a0"},     fail_a0,          e.fa);
      checkField({tag, ".cycle_count"}, cycle_count,      e.cnt);
    end
  endtask

  task automatic applyStimulus(input logic [NH-1:0] v, input logic [31:0] instr,
                               input logic [32*NH-1:0] a0);
    retire_valid = v;
    retire_instr = {NH{instr}};
    retire_a0    = a0;
    @(posedge clk);
    #1;
    retire_valid = '0;
    retire_instr = '0;
    retire_a0    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus('0, NOP, '0);
  endtask

  task automatic startRun();
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    retire_valid = '0;
    retire_instr = '0;
    retire_a0    = '0;
    repeat (2) @(posedge clk);
    #1;
    pushExpect(0, 0, 0, 4'h0, 0, 32'h0, 0);
    checkOutput("reset");
    reset_n = 1'b1;

    $display("[TB] all harts retire 10 NOPs then WFI with a0=0");
    startRun();
    pushExpect(0, 0, 0, 4'h0, 0, 32'h0, 0);
    checkOutput("run_start");
    repeat (10) applyStimulus(4'hF, NOP, '0);
    pushExpect(0, 0, 0, 4'h0, 0, 32'h0, 10);
    checkOutput("after_nops");
    pushExpect(1, 1, 0, 4'hF, 0, 32'h0, 11);
    applyStimulus(4'hF, WFI, '0);
    checkOutput("single_pass");
    pushExpect(1, 1, 0, 4'hF, 0, 32'h0, 11);
    applyStimulus(4'hF, WFI, a0v(9, 9, 9, 9));
    idle(2);
    checkOutput("done_frozen");

    $display("[TB] harts 2 and 1 fail in one cycle, 0 and 3 pass later");
    startRun();
    pushExpect(0, 0, 0, 4'b0110, 1, 32'h7, 1);
    applyStimulus(4'b0110, WFI, a0v(0, 5, 7, 0));
    checkOutput("same_cycle_fail");
    idle(1);
    pushExpect(1, 0, 0, 4'hF, 1, 32'h7, 3);
    applyStimulus(4'b1001, WFI, '0);
    checkOutput("multi_fail");

    $display("[TB] no WFI at all, expect timeout");
    startRun();
    idle(99);
    pushExpect(0, 0, 0, 4'h0, 0, 32'h0, 99);
    checkOutput("pre_timeout");
    pushExpect(1, 0, 1, 4'h0, 0, 32'h0, 100);
    idle(1);
    checkOutput("timeout");

    $display("[TB] earlier failure kept through timeout");
    startRun();
    idle(5);
    applyStimulus(4'b0100, WFI, a0v(0, 32'h33, 0, 0));
    idle(93);
    pushExpect(1, 0, 1, 4'b0100, 2, 32'h33, 100);
    idle(1);
    checkOutput("timeout_keep_fail");

    $display("[TB] last WFI on the final cycle before timeout");
    startRun();
    applyStimulus(4'b0111, WFI, '0);
    idle(98);
    pushExpect(1, 1, 0, 4'hF, 0, 32'h0, 100);
    applyStimulus(4'b1000, WFI, '0);
    checkOutput("late_pass");

    $display("[TB] repeated WFI on a finished hart is ignored");
    startRun();
    applyStimulus(4'b0001, WFI, '0);
    pushExpect(0, 0, 0, 4'b0001, 0, 32'h0, 2);
    applyStimulus(4'b0001, WFI, a0v(0, 0, 0, 9));
    checkOutput("repeat_wfi");
    pushExpect(1, 1, 0, 4'hF, 0, 32'h0, 3);
    applyStimulus(4'b1110, WFI, '0);
    checkOutput("repeat_pass");
    enable = 1'b0;
    pushExpect(0, 0, 0, 4'h0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    checkOutput("disable_clear");
    pushExpect(0, 0, 0, 4'h0, 0, 32'h0, 0);
    applyStimulus(4'hF, WFI, a0v(9, 9, 9, 9));
    checkOutput("idle_ignores_retire");

    $display("[TB] enable dropped mid-run aborts without verdict");
    enable = 1'b1;
    @(posedge clk);
    #1;
    pushExpect(0, 0, 0, 4'b0010, 1, 32'h4, 1);
    applyStimulus(4'b0010, WFI, a0v(0, 0, 4, 0));
    checkOutput("mid_run");
    enable = 1'b0;
    pushExpect(0, 0, 0, 4'h0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    checkOutput("abort_run");

    $display("[TB] asynchronous reset mid-run");
    enable = 1'b1;
    @(posedge clk);
    #1;
    pushExpect(0, 0, 0, 4'b1000, 3, 32'h8, 1);
    applyStimulus(4'b1000, WFI, a0v(8, 0, 0, 0));
    checkOutput("pre_reset");
    #2;
    reset_n = 1'b0;
    #1;
    pushExpect(0, 0, 0, 4'h0, 0, 32'h0, 0);
    checkOutput("async_reset");
    enable = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/test_status_monitor.md
Name: test_status_monitor

Overview:
- Simulation/verification-side monitor; sits beside the SoC DUT in the bench top.
- Watches the retired-instruction stream of 1..N harts and detects the end-of-test WFI (32'h10500073) on each hart.
- Captures each hart's a0 result at that point and produces a single done/pass/timeout verdict with a failing-hart report.
- Replaces ad-hoc single-hart wfi/a0 probes with a parametrised, clocked, self-checking block.

Parameters:
- NUM_HARTS, 1, number of monitored harts (1..16).
- WFI_OPCODE, 32'h10500073, instruction word that marks end of test.
- PASS_VALUE, 32'h0, a0 value meaning pass.
- TIMEOUT_CYCLES, 1000000, cycles in RUN before a forced timeout verdict (must be >= 2).
- CNT_W, 32, width of cycle_count.
- IDX_W, max(1,$clog2(NUM_HARTS)), width of hart index outputs (derived; not overridden).
- STALL_CYCLES, 4096, idle-retire limit (used only with the optional feature).

Ports:
- clk  in  1  monitor clock (same as DUT core clock).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  high = test running; low = return to IDLE.
- retire_valid  in  NUM_HARTS  per-hart instruction-retired strobe.
- retire_instr  in  32*NUM_HARTS  retired instruction word; hart i at [32*i+:32].
- retire_a0  in  32*NUM_HARTS  register x10 value for hart i, sampled with retire_valid[i].
- hart_done  out  NUM_HARTS  sticky per-hart WFI-seen flags.
- done  out  1  verdict valid (level, sticky).
- pass  out  1  all harts finished with a0 == PASS_VALUE; meaningful only when done=1.
- timeout  out  1  verdict forced by timeout or stall.
- fail_hart  out  IDX_W  index of first failing hart.
- fail_a0  out  32  a0 captured from fail_hart.
- cycle_count  out  CNT_W  cycles spent in RUN, saturating.

Behaviour:
- Reset: all outputs 0; state IDLE. Reset is async assert, sync deassert assumed upstream. Reset mid-RUN discards all captured state.
- States: IDLE, RUN, DONE.
- IDLE
  - All outputs held 0.
  - enable=1 -> RUN on the next edge.
- RUN
  - cycle_count increments every cycle; saturates at all-ones.
  - hit[i] = retire_valid[i] && retire_instr[i]==WFI_OPCODE && !hart_done[i].
  - On hit[i], hart_done[i] <= 1. A second WFI on an already-done hart is ignored; no a0 recapture.
  - Fail recording, first failure only: if hit[i] and retire_a0[i] != PASS_VALUE and no failure is recorded yet, then fail_hart <= i and fail_a0 <= retire_a0[i]. If several harts fail in the same cycle, the lowest index wins.
  - Completion: if (hart_done | hit) is all ones -> DONE, done <= 1, pass <= (no failure recorded, including same-cycle). done is visible one cycle after the last hart's WFI retire cycle.
  - Timeout: if cycle_count == TIMEOUT_CYCLES-1 and completion is not occurring -> DONE, done=1, timeout=1, pass=0. fail_hart and fail_a0 keep any earlier failure, otherwise stay 0.
  - Completion and timeout in the same cycle: completion wins, timeout=0.
- DONE
  - All outputs frozen; retire inputs ignored.
  - enable=0 -> IDLE, which clears all outputs.
- enable deasserted in RUN -> IDLE immediately, no verdict.
- retire_* inputs are ignored outside RUN.

Optional Feature:
- Macro: TEST_STATUS_MONITOR_STALL_DETECT_EN.
- Defined:
  - One stall counter per hart, cleared on retire_valid[i] and held at 0 once hart_done[i]=1.
  - Increments otherwise in RUN.
  - When any counter reaches STALL_CYCLES: -> DONE, timeout=1, pass=0, fail_hart = lowest stalled hart index, fail_a0 = 32'hDEAD_57A1.
  - Completion in the same cycle wins over a stall.
- Undefined: no stall counters; only the global TIMEOUT_CYCLES limit applies.

Test Plan:
- NUM_HARTS=1: enable, retire 10 NOPs, then WFI with a0=0 -> done=1, pass=1 one cycle later; cycle_count=11; timeout=0.
- NUM_HARTS=4: harts 2 and 1 retire WFI with a0=5 and a0=7 in the same cycle, harts 0 and 3 later with a0=0 -> done=1, pass=0, fail_hart=1, fail_a0=7, hart_done=4'hF.
- TIMEOUT_CYCLES=100, no WFI -> done=1, timeout=1, pass=0 exactly 100 cycles after entering RUN; fail_hart=0.
- TIMEOUT_CYCLES=100, last WFI (a0=0) retires on cycle 99 -> pass=1, timeout=0.
- Repeated WFI on a done hart with a0=9 after a first WFI with a0=0 -> no fail recorded. Then enable=0 -> all outputs 0 next cycle. Then reset_n low mid-RUN -> outputs 0 asynchronously.
- With TEST_STATUS_MONITOR_STALL_DETECT_EN, STALL_CYCLES=16: hart 1 never retires -> timeout=1, fail_hart=1, fail_a0=32'hDEAD57A1 after 16 idle cycles.
